// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store front end.
// No logic; sizes, FSM states, the registered-request record and an alignment helper.
// Not applicable (no datapath in this file).
package mem_pkg;

    localparam int BUS_DATA_WIDTH = 32;
    localparam int BUS_BE_WIDTH   = 4;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic                      write;
        logic [1:0]                size;
        logic                      is_unsigned;
        logic [1:0]                offset;
        logic [BUS_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    // Size 11 is reported separately as illegal, so it is never "misaligned" here.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and replication, load extraction and extension.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are used.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]                size,
    input  logic [1:0]                offset,
    input  logic                      is_unsigned,
    input  logic [BUS_DATA_WIDTH-1:0] st_dat,
    input  logic [BUS_DATA_WIDTH-1:0] ld_raw_dat,
    output logic [BUS_BE_WIDTH-1:0]   be,
    output logic [BUS_DATA_WIDTH-1:0] st_rep_dat,
    output logic [BUS_DATA_WIDTH-1:0] ld_ext_dat
);

    logic [BUS_DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted    = ld_raw_dat >> {offset, 3'b000};
        be         = '0;
        st_rep_dat = '0;
        ld_ext_dat = '0;
        case (size)
            SIZE_B: begin
                be         = 4'b0001 << offset;
                st_rep_dat = {4{st_dat[7:0]}};
                ld_ext_dat = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                st_rep_dat = {2{st_dat[15:0]}};
                ld_ext_dat = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                be         = 4'b1111;
                st_rep_dat = st_dat;
                ld_ext_dat = shifted;
            end
            default: begin
                be         = '0;
                st_rep_dat = '0;
                ld_ext_dat = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: checks a core request, drives one decoder bus cycle, returns a response.
// Latency from request handshake: error 1 cycle, store 2, load 2+READ_LATENCY.
// One transaction in flight; req_ready only in IDLE, response held until rsp_ready.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [31:0]               req_addr,
    input  logic [BUS_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [BUS_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_error,
    output logic                      bus_wen,
    output logic                      bus_ren,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic [BUS_BE_WIDTH-1:0]   bus_be,
    output logic [BUS_DATA_WIDTH-1:0] bus_wdata,
    input  logic [BUS_DATA_WIDTH-1:0] bus_rdata
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    mem_state_e                state, state_nxt;
    mem_req_t                  req_q;
    logic [ADDR_WIDTH-3:0]     bus_addr_hi_q;
    logic [BUS_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                      rsp_error_q;
    logic [1:0]                lat_cnt;

    logic                      req_hs;
    logic                      req_err;
    logic                      rd_sample;
    logic [BUS_BE_WIDTH-1:0]   lane_be;
    logic [BUS_DATA_WIDTH-1:0] lane_st_dat;
    logic [BUS_DATA_WIDTH-1:0] lane_ld_dat;

    assign req_hs    = req_valid && (state == IDLE);
    assign req_err   = (req_size == 2'b11)
                     || size_misaligned(req_size, req_addr[1:0])
                     || ((req_addr >> ADDR_WIDTH) != 32'd0);
    assign rd_sample = (state == WAIT) && (lat_cnt == LAT_LAST);

    mem_lane_align u_lane_align (
        .size        (req_q.size),
        .offset      (req_q.offset),
        .is_unsigned (req_q.is_unsigned),
        .st_dat      (req_q.wdata),
        .ld_raw_dat  (bus_rdata),
        .be          (lane_be),
        .st_rep_dat  (lane_st_dat),
        .ld_ext_dat  (lane_ld_dat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            req_q         <= '0;
            bus_addr_hi_q <= '0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            lat_cnt       <= '0;
        end else begin
            state <= state_nxt;
            if (req_hs) begin
                req_q.write       <= req_write;
                req_q.size        <= req_size;
                req_q.is_unsigned <= req_unsigned;
                req_q.offset      <= req_addr[1:0];
                req_q.wdata       <= req_wdata;
                rsp_error_q       <= req_err;
                rsp_rdata_q       <= '0;
                // A rejected request never reaches the bus, so the bus address keeps its old value.
                if (!req_err) begin
                    bus_addr_hi_q <= req_addr[ADDR_WIDTH-1:2];
                end
            end
            if (state == ISSUE) begin
                lat_cnt <= '0;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            if (rd_sample) begin
                rsp_rdata_q <= lane_ld_dat;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        bus_wen   = 1'b0;
        bus_ren   = 1'b0;
        bus_be    = '0;
        bus_wdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                bus_wen   = req_q.write;
                bus_ren   = ~req_q.write;
                bus_be    = lane_be;
                bus_wdata = req_q.write ? lane_st_dat : '0;
                state_nxt = req_q.write ? RESP : WAIT;
            end
            WAIT: begin
                if (rd_sample) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_addr  = {bus_addr_hi_q, 2'b00};
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized traffic against a byte-array model.
module tb_mem_access_unit;

    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        bus_wen;
    logic        bus_ren;
    logic [AW-1:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .bus_wen      (bus_wen),
        .bus_ren      (bus_ren),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata)
    );

    logic [7:0] bus_mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic          ren_prev = 1'b0;
    logic [AW-1:0] ren_addr = '0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Decoder-side memory: read data is valid exactly one cycle after the bus_ren cycle, junk otherwise.
    always @(negedge clk) begin
        if (ren_prev)
            bus_rdata = {bus_mem[{ren_addr[15:2], 2'd3}], bus_mem[{ren_addr[15:2], 2'd2}],
                         bus_mem[{ren_addr[15:2], 2'd1}], bus_mem[{ren_addr[15:2], 2'd0}]};
        else
            bus_rdata = $urandom;
        ren_prev = bus_ren;
        ren_addr = bus_addr;
        if (bus_wen) begin
            for (int i = 0; i < 4; i++)
                if (bus_be[i]) bus_mem[{bus_addr[15:2], 2'(i)}] = bus_wdata[8*i +: 8];
        end
    end

    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input int bp);
        int          n;
        bit          err;
        int          exp_k;
        int          k;
        int          off;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;

        n = (sz == 2'b11) ? 0 : (1 << sz);
        if (sz == 2'b11) err = 1'b1;
        else err = (addr[31:AW] != 0) || ((addr % n) != 0);
        exp_k  = err ? 1 : (wr ? 2 : 3);
        off    = int'(addr % 4);
        exp_be = '0;
        exp_wd = '0;
        exp_rd = '0;
        if (!err) begin
            exp_be = ((1 << n) - 1) << off;
            for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
            if (!wr) begin
                for (int j = 0; j < n; j++) exp_rd[8*j +: 8] = ref_mem[addr[15:0] + 16'(j)];
                if (!uns && n < 4 && exp_rd[8*n-1])
                    for (int j = n; j < 4; j++) exp_rd[8*j +: 8] = 8'hFF;
            end else begin
                for (int j = 0; j < n; j++) ref_mem[addr[15:0] + 16'(j)] = wd[8*j +: 8];
            end
        end

        @(negedge clk);
        check("idle_req_ready", req_ready, 1);
        check("idle_no_strobe", {bus_wen, bus_ren}, 0);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        k = 1;
        while (1) begin
            check("wen", bus_wen, (k == 1 && !err && wr));
            check("ren", bus_ren, (k == 1 && !err && !wr));
            if (k == 1 && !err) begin
                check("bus_addr", bus_addr, {addr[15:2], 2'b00});
                check("bus_be", bus_be, exp_be);
                if (wr) check("bus_wdata", bus_wdata, exp_wd);
            end else begin
                check("be_quiet", bus_be, 0);
                check("wdata_quiet", bus_wdata, 0);
            end
            check("rsp_valid_timing", rsp_valid, (k >= exp_k));
            if (k >= exp_k) break;
            k++;
            @(negedge clk);
        end
        check("rsp_error", rsp_error, err);
        check("rsp_rdata", rsp_rdata, exp_rd);

        for (int b = 0; b < bp; b++) begin
            req_valid    = 1'($urandom_range(0, 1));
            req_write    = 1'($urandom);
            req_size     = 2'($urandom);
            req_addr     = 32'h4000 + $urandom_range(0, 63);
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, exp_rd);
            check("bp_error", rsp_error, err);
            check("bp_req_ready", req_ready, 0);
            check("bp_strobe", {bus_wen, bus_ren}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("post_req_ready", req_ready, 1);
        check("post_rsp_valid", rsp_valid, 0);
    endtask

    task automatic reset_mid(input int at_k);
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h2008;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k < at_k; k++) @(negedge clk);
        check("pre_rst_addr", bus_addr, 32'h2008);
        #2 rst = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_strobes", {bus_wen, bus_ren}, 0);
        check("rst_be", bus_be, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_error", rsp_error, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid, 0);
            check("rst_idle", req_ready, 1);
        end
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            bus_mem[i] = v;
            ref_mem[i] = v;
        end

        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_error", rsp_error, 0);
        check("reset_strobes", {bus_wen, bus_ren}, 0);
        check("reset_bus_addr", bus_addr, 0);
        check("reset_bus_be", bus_be, 0);
        check("reset_bus_wdata", bus_wdata, 0);
        rst = 1'b1;

        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_2004, 32'hDEAD_BEEF, 0);
        run_txn(1'b1, 2'b00, 1'b0, 32'h0000_3003, 32'h0000_00A5, 0);
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_BEEF, 0);

        {bus_mem[16'h2003], bus_mem[16'h2002], bus_mem[16'h2001], bus_mem[16'h2000]} = 32'h1280_3456;
        {ref_mem[16'h2003], ref_mem[16'h2002], ref_mem[16'h2001], ref_mem[16'h2000]} = 32'h1280_3456;
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_2002, 32'h0, 0);
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_2002, 32'h0, 0);
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 0);

        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_2001, 32'h0, 0);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 0);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, 0);
        run_txn(1'b1, 2'b11, 1'b0, 32'h0000_2000, 32'h1234_5678, 0);

        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 5);

        reset_mid(2);
        reset_mid(1);

        for (int t = 0; t < 300; t++) begin
            int          r;
            logic [1:0]  sz;
            logic [31:0] addr;
            r    = $urandom_range(0, 9);
            sz   = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            addr = 32'h4000 + $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) addr = addr | (32'h1 << $urandom_range(16, 31));
            run_txn(1'($urandom), sz, 1'($urandom), addr, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
